// File: rtl/sched_pkg.sv
// Shared types and constants for the scheduler request path.
package sched_pkg;

  localparam int ADDR_WIDTH_DEF = 13;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int STALL_CNT_W    = 16;

  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic                      we;
    logic [DATA_WIDTH_DEF-1:0] wdata;
  } sched_req_t;

endpackage

// File: rtl/req_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head entry is read combinationally.
module req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage carries no reset: entries are only observed once the pointers say so.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sched_req_queue.sv
// Walker-side request buffer in front of scheduler_dual, with read-response return.
// Optional stall-cycle counter enabled by defining SCHED_REQ_STALL_CNT_EN.
module sched_req_queue
  import sched_pkg::*;
#(
  parameter int          ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int          DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int          DEPTH      = 4,
  parameter int          READ_LAT   = 1,
  parameter int unsigned lower_addr = 0,
  parameter int unsigned upper_addr = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic                     req_we,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     sched_valid,
  output logic [ADDR_WIDTH-1:0]    sched_addr,
  output logic                     sched_we,
  output logic [DATA_WIDTH-1:0]    sched_data,
  input  logic                     sched_stall,
  input  logic [DATA_WIDTH-1:0]    sched_rdata,
  output logic                     rsp_valid,
  output logic [ADDR_WIDTH-1:0]    rsp_addr,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     range_err,
  output logic [$clog2(DEPTH):0]   count
`ifdef SCHED_REQ_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0]   stall_cycles
`endif
);

  // Handshake: a request transfers on a rising edge with req_valid && req_ready;
  // the head retires on a rising edge with sched_valid && !sched_stall.

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  localparam logic [ADDR_WIDTH-1:0] LO   = ADDR_WIDTH'(lower_addr);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(upper_addr - lower_addr);

  req_t tail;
  req_t head;
  logic full;
  logic empty;
  logic accept;
  logic in_range;
  logic push;
  logic pop;

  // Offset compare covers both bounds in one unsigned test (needs lower <= upper).
  assign in_range = (req_addr - LO) <= SPAN;
  assign req_ready = !full;
  assign accept    = req_valid && req_ready;
  assign push      = accept && in_range;
  assign pop       = sched_valid && !sched_stall;
  assign tail      = '{addr: req_addr, we: req_we, wdata: req_wdata};

  req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(req_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (tail),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign sched_valid = !empty;
  assign sched_addr  = head.addr;
  assign sched_we    = sched_valid && head.we;
  assign sched_data  = head.wdata;

  logic                  tag_v [READ_LAT];
  logic [ADDR_WIDTH-1:0] tag_a [READ_LAT];

  // The last tag stage lines up with the cycle in which sched_rdata is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LAT; i++) begin
        tag_v[i] <= 1'b0;
        tag_a[i] <= '0;
      end
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      rsp_data  <= '0;
      range_err <= 1'b0;
    end else begin
      tag_v[0] <= pop && !head.we;
      tag_a[0] <= head.addr;
      for (int i = 1; i < READ_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_a[i] <= tag_a[i-1];
      end
      rsp_valid <= tag_v[READ_LAT-1];
      if (tag_v[READ_LAT-1]) begin
        rsp_addr <= tag_a[READ_LAT-1];
        rsp_data <= sched_rdata;
      end
      range_err <= accept && !in_range;
    end
  end

`ifdef SCHED_REQ_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (sched_valid && sched_stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sched_req_queue.sv
// Cycle-level bench for sched_req_queue against a queue-based reference model.
module tb_sched_req_queue;
  import sched_pkg::*;

  localparam int AW       = ADDR_WIDTH_DEF;
  localparam int DW       = DATA_WIDTH_DEF;
  localparam int DEPTH    = 4;
  localparam int READ_LAT = 1;
  localparam int LO       = 0;
  localparam int HI       = 4;
  localparam int RW       = AW + DW;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic          req_we = 1'b0;
  logic [DW-1:0] req_wdata = '0;
  logic          sched_valid;
  logic [AW-1:0] sched_addr;
  logic          sched_we;
  logic [DW-1:0] sched_data;
  logic          sched_stall = 1'b0;
  logic [DW-1:0] sched_rdata = '0;
  logic          rsp_valid;
  logic [AW-1:0] rsp_addr;
  logic [DW-1:0] rsp_data;
  logic          range_err;
  logic [$clog2(DEPTH):0] count;
`ifdef SCHED_REQ_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cycles;
`endif

  sched_req_queue #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .READ_LAT   (READ_LAT),
    .lower_addr (LO),
    .upper_addr (HI)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_we      (req_we),
    .req_wdata   (req_wdata),
    .sched_valid (sched_valid),
    .sched_addr  (sched_addr),
    .sched_we    (sched_we),
    .sched_data  (sched_data),
    .sched_stall (sched_stall),
    .sched_rdata (sched_rdata),
    .rsp_valid   (rsp_valid),
    .rsp_addr    (rsp_addr),
    .rsp_data    (rsp_data),
    .range_err   (range_err),
    .count       (count)
`ifdef SCHED_REQ_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // Reference model: queued requests, reads awaiting data, expected responses
  sched_req_t    mq[$];
  logic [AW-1:0] pend_a[$];
  int            pend_t[$];
  logic [RW-1:0] exp_q[$];
  int            exp_t[$];
  logic          m_rerr = 1'b0;
  int            m_stall = 0;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    pend_a.delete();
    pend_t.delete();
    exp_q.delete();
    exp_t.delete();
    m_rerr = 1'b0;
    m_stall = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_count"}, count, 0);
    check_eq({tag, "_req_ready"}, req_ready, 1);
    check_eq({tag, "_sched_valid"}, sched_valid, 0);
    check_eq({tag, "_sched_we"}, sched_we, 0);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
    check_eq({tag, "_rsp_addr"}, rsp_addr, 0);
    check_eq({tag, "_rsp_data"}, rsp_data, 0);
    check_eq({tag, "_range_err"}, range_err, 0);
`ifdef SCHED_REQ_STALL_CNT_EN
    check_eq({tag, "_stall_cycles"}, stall_cycles, 0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0;
    sched_stall = 1'b0;
    #1;
    model_clear();
    check_reset_values("rst_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst_hold");
    rst_n = 1'b1;
  endtask

  // One clock cycle: check outputs against the model, drive inputs, advance the model.
  task automatic tick(input logic v, input logic [AW-1:0] a, input logic we,
                      input logic [DW-1:0] d, input logic stall, input logic [DW-1:0] rd,
                      output logic accepted);
    sched_req_t head;
    sched_req_t item;
    logic       acc;
    logic       in_rng;
    int         ai;
    @(negedge clk);
    check_eq("count", count, mq.size());
    check_eq("req_ready", req_ready, mq.size() < DEPTH);
    check_eq("sched_valid", sched_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      head = mq[0];
      check_eq("sched_addr", sched_addr, head.addr);
      check_eq("sched_we", sched_we, head.we);
      check_eq("sched_data", sched_data, head.wdata);
    end else begin
      head = '0;
      check_eq("sched_we_idle", sched_we, 0);
    end
    check_eq("range_err", range_err, m_rerr);
    if (exp_t.size() != 0 && exp_t[0] == cyc) begin
      check_eq("rsp_valid", rsp_valid, 1);
      check_eq("rsp_addr", rsp_addr, exp_q[0][RW-1:DW]);
      check_eq("rsp_data", rsp_data, exp_q[0][DW-1:0]);
      void'(exp_q.pop_front());
      void'(exp_t.pop_front());
    end else begin
      check_eq("rsp_valid_idle", rsp_valid, 0);
    end
`ifdef SCHED_REQ_STALL_CNT_EN
    check_eq("stall_cycles", stall_cycles, m_stall);
`endif

    req_valid   = v;
    req_addr    = a;
    req_we      = we;
    req_wdata   = d;
    sched_stall = stall;
    sched_rdata = rd;

    ai     = int'(a);
    in_rng = (ai >= LO) && (ai <= HI);
    acc    = v && (mq.size() < DEPTH);
    if (pend_t.size() != 0 && pend_t[0] == cyc) begin
      exp_q.push_back({pend_a[0], rd});
      exp_t.push_back(cyc + 1);
      void'(pend_a.pop_front());
      void'(pend_t.pop_front());
    end
    if (mq.size() != 0 && stall && m_stall < 16'hFFFF) m_stall++;
    if (mq.size() != 0 && !stall) begin
      if (!head.we) begin
        pend_a.push_back(head.addr);
        pend_t.push_back(cyc + READ_LAT);
      end
      void'(mq.pop_front());
    end
    if (acc && in_rng) begin
      item.addr  = a;
      item.we    = we;
      item.wdata = d;
      mq.push_back(item);
    end
    m_rerr = acc && !in_rng;
    @(posedge clk);
    accepted = acc;
  endtask

  // Driver: hold one request until it is taken, with a bounded wait.
  task automatic send(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] d,
                      input logic stall);
    logic acc;
    int   n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      tick(1'b1, a, we, d, stall, $urandom, acc);
      n++;
    end
    if (!acc) check_eq("send_timeout", req_ready, 1);
  endtask

  task automatic idle(input int n, input logic stall);
    logic acc;
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, '0, stall, $urandom, acc);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout @cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    // 1: single read, response READ_LAT+1 cycles after the pop
    do_reset();
    send(13'd2, 1'b0, 32'd0, 1'b0);
    tick(1'b0, '0, 1'b0, '0, 1'b0, 32'd0, acc);
    tick(1'b0, '0, 1'b0, '0, 1'b0, 32'd10, acc);
    idle(3, 1'b0);

    // 2: write held stable for 3 stalled cycles, pops on the 4th
    send(13'd1, 1'b1, 32'd100, 1'b0);
    idle(3, 1'b1);
    idle(3, 1'b0);

    // 3: fill under stall, 5th waits for space, drain in order
    for (int i = 1; i <= 4; i++) send(AW'(i), 1'b0, DW'(i), 1'b1);
    idle(2, 1'b1);
    send(13'd0, 1'b1, 32'd55, 1'b0);
    idle(8, 1'b0);

    // 4: out-of-range request
    send(13'd100, 1'b0, 32'd7, 1'b0);
    idle(3, 1'b0);
    send(13'd5, 1'b1, 32'd8, 1'b0);
    idle(2, 1'b0);

    // 5: reset with reads in flight
    send(13'd2, 1'b0, 32'd0, 1'b0);
    send(13'd3, 1'b0, 32'd0, 1'b0);
    do_reset();
    idle(6, 1'b0);

`ifdef SCHED_REQ_STALL_CNT_EN
    // 6: stall cycle counter
    send(13'd1, 1'b1, 32'd5, 1'b0);
    idle(7, 1'b1);
    idle(2, 1'b0);
    @(negedge clk);
    check_eq("stall_cycles_7", stall_cycles, 7);
`endif

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 2) != 0), AW'($urandom_range(0, 6)), $urandom_range(0, 1) == 1,
           $urandom, ($urandom_range(0, 3) == 0), $urandom, acc);
    end
    idle(10, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
